ula_arbiter: RTL

Shares the single 64-bit `ula` adder/subtractor between two requesters (e.g. execute stage and branch-compare logic) using round-robin arbitration. Each accepted request is latched, driven onto the ULA for one settle cycle, and returned with its result and a 4-bit flag vector on a shared, tagged response channel. One operation is in flight at a time.

---
 rtl/ula_arbiter_pkg.sv | 18 +
 rtl/ula_flags.sv | 31 +++
 rtl/ula_arbiter.sv | 119 +++++++++++
 3 files changed

// File: rtl/ula_arbiter_pkg.sv
// Shared definitions for the two-requester ULA arbiter: FSM encoding, flag
// bit positions and default datapath width.
package ula_arbiter_pkg;

    localparam int ULA_WIDTH = 64;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/ula_flags.sv
// Condition flags {V, C, N, Z} for one add/sub, derived from the operands
// actually presented to the ULA and the result it returned.
module ula_flags
    import ula_arbiter_pkg::*;
#(
    parameter int WIDTH = ULA_WIDTH
) (
    input  logic [WIDTH-1:0] i_s1,
    input  logic [WIDTH-1:0] i_s2,
    input  logic             i_sub,
    input  logic [WIDTH-1:0] i_res,
    output logic [3:0]       o_flags
);

    logic [WIDTH-1:0] w_s2_eff;
    logic [WIDTH:0]   w_sum;

    // Subtraction is s1 + ~s2 + 1, so carry-out 1 means no borrow.
    assign w_s2_eff = i_sub ? ~i_s2 : i_s2;
    assign w_sum    = {1'b0, i_s1} + {1'b0, w_s2_eff} + {{WIDTH{1'b0}}, i_sub};

    always_comb begin
        o_flags         = '0;
        o_flags[FLAG_Z] = (i_res == '0);
        o_flags[FLAG_N] = i_res[WIDTH-1];
        o_flags[FLAG_C] = w_sum[WIDTH];
        o_flags[FLAG_V] = (i_s1[WIDTH-1] == w_s2_eff[WIDTH-1]) &&
                          (i_res[WIDTH-1] != i_s1[WIDTH-1]);
    end

endmodule

// File: rtl/ula_arbiter.sv
// Round-robin share of one external 64-bit add/sub ULA between two
// requesters; one operation in flight, tagged registered response.
module ula_arbiter
    import ula_arbiter_pkg::*;
#(
    parameter int WIDTH = ULA_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [2*WIDTH-1:0] req_s1,
    input  logic [2*WIDTH-1:0] req_s2,
    input  logic [1:0]         req_sub,
    output logic [WIDTH-1:0]   ula_s1,
    output logic [WIDTH-1:0]   ula_s2,
    output logic               ula_sub,
    input  logic [WIDTH-1:0]   ula_res,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [WIDTH-1:0]   rsp_res,
    output logic [3:0]         rsp_flags
);

    state_t           r_state;
    logic             r_last_grant;
    logic             r_id;
    logic [WIDTH-1:0] r_ula_s1;
    logic [WIDTH-1:0] r_ula_s2;
    logic             r_ula_sub;
    logic             r_rsp_valid;
    logic             r_rsp_id;
    logic [WIDTH-1:0] r_rsp_res;
    logic [3:0]       r_rsp_flags;

    logic             w_any;
    logic             w_gid;
    logic [WIDTH-1:0] w_sel_s1;
    logic [WIDTH-1:0] w_sel_s2;
    logic             w_sel_sub;
    logic [3:0]       w_flags;

    // A tie goes to the requester that was not granted last.
    always_comb begin
        w_any = |req_valid;
        case (req_valid)
            2'b01:   w_gid = 1'b0;
            2'b10:   w_gid = 1'b1;
            default: w_gid = ~r_last_grant;
        endcase
        req_ready = '0;
        if (!rst && r_state == S_IDLE && w_any)
            req_ready[w_gid] = 1'b1;
    end

    assign w_sel_s1  = w_gid ? req_s1[2*WIDTH-1:WIDTH] : req_s1[WIDTH-1:0];
    assign w_sel_s2  = w_gid ? req_s2[2*WIDTH-1:WIDTH] : req_s2[WIDTH-1:0];
    assign w_sel_sub = w_gid ? req_sub[1] : req_sub[0];

    ula_flags #(.WIDTH(WIDTH)) u_flags (
        .i_s1    (r_ula_s1),
        .i_s2    (r_ula_s2),
        .i_sub   (r_ula_sub),
        .i_res   (ula_res),
        .o_flags (w_flags)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
            r_ula_s1     <= '0;
            r_ula_s2     <= '0;
            r_ula_sub    <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_res    <= '0;
            r_rsp_flags  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_ula_s1     <= w_sel_s1;
                        r_ula_s2     <= w_sel_s2;
                        r_ula_sub    <= w_sel_sub;
                        r_id         <= w_gid;
                        r_last_grant <= w_gid;
                        r_state      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_rsp_res   <= ula_res;
                    r_rsp_flags <= w_flags;
                    r_rsp_id    <= r_id;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ula_s1    = r_ula_s1;
    assign ula_s2    = r_ula_s2;
    assign ula_sub   = r_ula_sub;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_res   = r_rsp_res;
    assign rsp_flags = r_rsp_flags;

endmodule
